// File: rtl/data_cache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache for the MEM-stage data port.
// Load hits answer combinationally; misses and all stores go out over a req/ack memory bus.
module data_cache_responder #(
    parameter int unsigned SETS = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cache_enabled_i,
    input  logic [29:0] cache_address_i,
    input  logic [3:0]  cache_write_en_i,
    input  logic [31:0] cache_data_i,
    output logic [31:0] cache_data_o,
    output logic        cache_blocking_n_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [29:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int unsigned INDEX_BITS = $clog2(SETS);
    localparam int unsigned TAG_BITS   = 30 - INDEX_BITS;

    typedef enum logic [1:0] {StIdle, StRdMiss, StWrThru, StResp} state_e;

    state_e state_q, state_d;

    logic [SETS-1:0]     valid_q;
    logic [TAG_BITS-1:0] tag_q  [SETS];
    logic [31:0]         data_q [SETS];

    logic        mem_req_q;
    logic        mem_we_q;
    logic [29:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_wstrb_q;
    logic [31:0] resp_q;

    logic [INDEX_BITS-1:0] req_idx, lat_idx;
    logic [TAG_BITS-1:0]   req_tag, lat_tag;
    logic                  req_store, req_hit, lat_hit;
    logic                  start, fill, wr_done;

    assign req_idx   = cache_address_i[INDEX_BITS-1:0];
    assign req_tag   = cache_address_i[29:INDEX_BITS];
    assign req_store = |cache_write_en_i;
    assign req_hit   = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    assign lat_idx = mem_addr_q[INDEX_BITS-1:0];
    assign lat_tag = mem_addr_q[29:INDEX_BITS];
    assign lat_hit = valid_q[lat_idx] && (tag_q[lat_idx] == lat_tag);

    assign start   = (state_q == StIdle) && cache_enabled_i && (req_store || !req_hit);
    assign fill    = (state_q == StRdMiss) && mem_ack_i;
    assign wr_done = (state_q == StWrThru) && mem_ack_i;

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_wstrb_o = mem_wstrb_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (cache_enabled_i) begin
                    if (req_store) begin
                        state_d = StWrThru;
                    end else if (!req_hit) begin
                        state_d = StRdMiss;
                    end
                end
            end
            StRdMiss: if (mem_ack_i) state_d = StResp;
            StWrThru: if (mem_ack_i) state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        cache_blocking_n_o = 1'b1;
        cache_data_o       = '0;
        unique case (state_q)
            StIdle: begin
                if (cache_enabled_i) begin
                    if (!req_store && req_hit) begin
                        cache_data_o = data_q[req_idx];
                    end else begin
                        cache_blocking_n_o = 1'b0;
                    end
                end
            end
            StRdMiss, StWrThru: cache_blocking_n_o = 1'b0;
            StResp: cache_data_o = mem_we_q ? 32'h0 : resp_q;
            default: cache_blocking_n_o = 1'b1;
        endcase
    end

    // Request fields are frozen at launch so core-side changes during a stall are ignored.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            resp_q      <= '0;
            valid_q     <= '0;
            for (int i = 0; i < int'(SETS); i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            if (start) begin
                mem_req_q   <= 1'b1;
                mem_we_q    <= req_store;
                mem_addr_q  <= cache_address_i;
                mem_wdata_q <= cache_data_i;
                mem_wstrb_q <= cache_write_en_i;
            end
            if (fill) begin
                mem_req_q        <= 1'b0;
                valid_q[lat_idx] <= 1'b1;
                tag_q[lat_idx]   <= lat_tag;
                resp_q           <= mem_rdata_i;
            end
            if (wr_done) begin
                mem_req_q <= 1'b0;
            end
        end
    end

    // Line data needs no reset: it is only read behind a set valid bit.
    always_ff @(posedge clk_i) begin
        if (fill) begin
            data_q[lat_idx] <= mem_rdata_i;
        end else if (wr_done && lat_hit) begin
            for (int k = 0; k < 4; k++) begin
                if (mem_wstrb_q[k]) begin
                    data_q[lat_idx][8*k +: 8] <= mem_wdata_q[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_cache_responder.sv
// Self-checking bench for data_cache_responder: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level cache/memory model.
module tb_data_cache_responder;

    localparam int unsigned SETS = 64;

    logic        clk;
    logic        rst_i;
    logic        en;
    logic [29:0] addr;
    logic [3:0]  wen;
    logic [31:0] din;
    logic [31:0] dout;
    logic        blk_n;
    logic        mreq;
    logic        mwe;
    logic [29:0] maddr;
    logic [31:0] mwdata;
    logic [3:0]  mwstrb;
    logic        ack;
    logic [31:0] rdata;

    data_cache_responder #(.SETS(SETS)) dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .cache_enabled_i    (en),
        .cache_address_i    (addr),
        .cache_write_en_i   (wen),
        .cache_data_i       (din),
        .cache_data_o       (dout),
        .cache_blocking_n_o (blk_n),
        .mem_req_o          (mreq),
        .mem_we_o           (mwe),
        .mem_addr_o         (maddr),
        .mem_wdata_o        (mwdata),
        .mem_wstrb_o        (mwstrb),
        .mem_ack_i          (ack),
        .mem_rdata_i        (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int blk_low_cnt = 0;
    int req_hi_cnt = 0;
    logic [31:0] last_data;

    // Expected outputs for the current cycle, set by the stimulus process.
    logic        exp_blk, exp_chk_data, exp_req, exp_mem, exp_we, exp_chk_wdata;
    logic [31:0] exp_data, exp_wdata;
    logic [29:0] exp_addr;
    logic [3:0]  exp_wstrb;

    // Model: backing memory plus direct-mapped line contents keyed by full word address.
    logic [31:0] mem [logic [29:0]];
    bit          m_valid [SETS];
    logic [29:0] m_addr  [SETS];
    logic [31:0] m_data  [SETS];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] memrd(input logic [29:0] a);
        if (mem.exists(a)) return mem[a];
        return (32'(a) * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) if (strb[k]) r[8*k +: 8] = nw[8*k +: 8];
        return r;
    endfunction

    task automatic set_reset_exp();
        exp_blk = 1'b1; exp_chk_data = 1'b1; exp_data = '0; exp_req = 1'b0;
        exp_mem = 1'b1; exp_we = 1'b0; exp_addr = '0; exp_wstrb = '0;
        exp_chk_wdata = 1'b1; exp_wdata = '0;
    endtask

    task automatic junk();
        en   = 1'($urandom);
        addr = 30'($urandom);
        wen  = 4'($urandom);
        din  = $urandom;
    endtask

    always @(negedge clk) begin
        chk("blocking_n", 32'(blk_n), 32'(exp_blk));
        if (exp_chk_data) chk("load_data", dout, exp_data);
        chk("mem_req", 32'(mreq), 32'(exp_req));
        if (exp_mem) begin
            chk("mem_we", 32'(mwe), 32'(exp_we));
            chk("mem_addr", 32'(maddr), 32'(exp_addr));
            chk("mem_wstrb", 32'(mwstrb), 32'(exp_wstrb));
            if (exp_chk_wdata) chk("mem_wdata", mwdata, exp_wdata);
        end
        if (!blk_n) blk_low_cnt++;
        if (mreq) req_hi_cnt++;
    end

    // One core request; ack arrives k cycles after mem_req_o rises.
    task automatic do_req(input logic [29:0] a, input logic [3:0] we, input logic [31:0] wd,
                          input int k);
        int idx;
        bit hit;
        idx = int'(a[5:0]);
        hit = m_valid[idx] && (m_addr[idx] == a);
        @(posedge clk); #1;
        blk_low_cnt = 0; req_hi_cnt = 0;
        ack = 1'b0; en = 1'b1; addr = a; wen = we; din = wd;
        exp_req = 1'b0; exp_mem = 1'b0; exp_chk_wdata = 1'b0;
        if (we == 4'b0 && hit) begin
            exp_blk = 1'b1; exp_chk_data = 1'b1; exp_data = m_data[idx];
            @(negedge clk);
            last_data = dout;
            return;
        end
        exp_blk = 1'b0; exp_chk_data = 1'b0;
        for (int c = 1; c <= 1 + k; c++) begin
            @(posedge clk); #1;
            junk();
            exp_req = 1'b1; exp_mem = 1'b1; exp_we = (we != 4'b0); exp_addr = a;
            exp_wstrb = we; exp_chk_wdata = (we != 4'b0); exp_wdata = wd;
            if (c == 1 + k) begin
                ack = 1'b1;
                rdata = (we == 4'b0) ? memrd(a) : $urandom;
            end
        end
        @(posedge clk); #1;
        ack = 1'b0; rdata = $urandom; junk();
        exp_req = 1'b0; exp_mem = 1'b0; exp_blk = 1'b1; exp_chk_data = 1'b1;
        if (we == 4'b0) begin
            exp_data = memrd(a);
            m_valid[idx] = 1'b1; m_addr[idx] = a; m_data[idx] = memrd(a);
        end else begin
            exp_data = '0;
            mem[a] = merge(memrd(a), wd, we);
            if (hit) m_data[idx] = merge(m_data[idx], wd, we);
        end
        @(negedge clk);
        last_data = dout;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        en = 1'b0; addr = 30'($urandom); wen = 4'($urandom); din = $urandom;
        ack = ($urandom_range(0, 2) == 0); rdata = $urandom;
        exp_blk = 1'b1; exp_chk_data = 1'b0; exp_req = 1'b0; exp_mem = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [29:0] a;
        logic [3:0]  we;
        rst_i = 1'b0; en = 1'b0; addr = '0; wen = '0; din = '0; ack = 1'b0; rdata = '0;
        last_data = '0;
        set_reset_exp();
        for (int i = 0; i < int'(SETS); i++) begin
            m_valid[i] = 1'b0; m_addr[i] = '0; m_data[i] = '0;
        end
        mem[30'h040] = 32'h1122_3344;

        #3;
        chk("rst_blocking_n", 32'(blk_n), 32'd1);
        chk("rst_mem_req", 32'(mreq), 32'd0);
        chk("rst_data", dout, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b1;
        exp_mem = 1'b0;

        // Cold load miss with ack two cycles after the request rises.
        do_req(30'h040, 4'b0, 32'h0, 2);
        chk("miss_stall_len", 32'(blk_low_cnt), 32'd4);
        chk("miss_req_width", 32'(req_hi_cnt), 32'd3);
        chk("miss_resp_data", last_data, 32'h1122_3344);

        do_req(30'h040, 4'b0, 32'h0, 0);
        chk("hit_stall_len", 32'(blk_low_cnt), 32'd0);
        chk("hit_req_width", 32'(req_hi_cnt), 32'd0);
        chk("hit_data", last_data, 32'h1122_3344);

        do_req(30'h040, 4'b0010, 32'h0000_AB00, 0);
        chk("store_stall_len", 32'(blk_low_cnt), 32'd2);
        chk("store_resp_data", last_data, 32'd0);
        do_req(30'h040, 4'b0, 32'h0, 0);
        chk("merged_hit_req", 32'(req_hi_cnt), 32'd0);
        chk("merged_hit_data", last_data, 32'h1122_AB44);

        // Store to uncached 0x200 must not allocate.
        do_req(30'h080, 4'b1111, 32'hCAFE_F00D, 1);
        do_req(30'h080, 4'b0, 32'h0, 1);
        chk("no_alloc_req_width", 32'(req_hi_cnt), 32'd2);
        chk("no_alloc_data", last_data, 32'hCAFE_F00D);

        // Conflict on index 0.
        do_req(30'h040, 4'b0, 32'h0, 0);
        chk("conflict1_req", 32'(req_hi_cnt), 32'd1);
        chk("conflict1_data", last_data, 32'h1122_AB44);
        do_req(30'h080, 4'b0, 32'h0, 0);
        chk("conflict2_req", 32'(req_hi_cnt), 32'd1);
        chk("conflict2_data", last_data, 32'hCAFE_F00D);
        do_req(30'h040, 4'b0, 32'h0, 0);
        chk("conflict3_req", 32'(req_hi_cnt), 32'd1);

        // Reset while a read miss is outstanding, followed by a late ack.
        @(posedge clk); #1;
        ack = 1'b0; en = 1'b1; addr = 30'h0C0; wen = 4'b0; din = '0;
        exp_blk = 1'b0; exp_chk_data = 1'b0; exp_req = 1'b0; exp_mem = 1'b0;
        @(posedge clk); #1;
        junk();
        exp_req = 1'b1; exp_mem = 1'b1; exp_we = 1'b0; exp_addr = 30'h0C0; exp_wstrb = '0;
        exp_chk_wdata = 1'b0;
        @(negedge clk); #1;
        en = 1'b0; rst_i = 1'b0;
        set_reset_exp();
        for (int i = 0; i < int'(SETS); i++) m_valid[i] = 1'b0;
        #1;
        chk("async_rst_req", 32'(mreq), 32'd0);
        chk("async_rst_blocking_n", 32'(blk_n), 32'd1);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst_i = 1'b1;
        @(posedge clk); #1 ack = 1'b1; rdata = $urandom;
        @(posedge clk); #1 ack = 1'b0;
        @(negedge clk);
        exp_mem = 1'b0;
        do_req(30'h040, 4'b0, 32'h0, 1);
        chk("post_rst_req", 32'(req_hi_cnt), 32'd2);
        chk("post_rst_data", last_data, 32'h1122_AB44);

        // Randomized traffic over a small address pool so hits, conflicts and merges occur.
        for (int t = 0; t < 400; t++) begin
            a = 30'(($urandom_range(0, 3) << 6) | $urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) we = 4'($urandom_range(1, 15));
            else we = 4'b0;
            do_req(a, we, $urandom, int'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
